cp0_reg_file: RTL and testbench
===============================

// Module: cp0_reg_file
// PURPOSE
//  Coprocessor-0 register file: services the CP0 read/write requests decoded in ID (MFC0/MTC0)
//  and records exceptions signalled from MEM. Holds BadVAddr, Count, Compare, Status, Cause, EPC;
//  runs the Count/Compare timer and flags pending interrupts to the exception unit.
// PARAMETERS
//  COUNT_DIV  2  Count increments once every COUNT_DIV clocks (1..4)
//  INT_NUM    6  hardware interrupt lines, mapped to Cause.IP[7:2]
// PORTS
//  clk            in   1   clock; all state updates on posedge
//  rst            in   1   reset; synchronous, active-low
//  cp_read_en     in   1   read request (MFC0 in ID)
//  cp_read_addr   in   5   CP0 register number to read
//  cp_read_data   out  32  read data; combinational, 0 when !cp_read_en or unmapped
//  cp_write_en    in   1   write request (MTC0 reaching WB)
//  cp_write_addr  in   5   CP0 register number to write
//  cp_write_data  in   32  write data
//  hw_int         in   6   level-sensitive external interrupt lines
//  exc_en         in   1   exception taken this cycle
//  exc_code       in   5   ExcCode to record in Cause[6:2]
//  exc_pc         in   32  PC of faulting instruction
//  exc_delay_slot in   1   faulting instruction in branch delay slot
//  exc_badvaddr   in   32  faulting address (AdEL/AdES only)
//  eret           in   1   ERET committing this cycle
//  status         out  32  Status register value
//  cause          out  32  Cause register value
//  epc            out  32  EPC register value
//  int_pending    out  1   Status.IE & !Status.EXL & |(Cause.IP & Status.IM)
// BEHAVIOUR
//  Reset (rst==0 at posedge): Count=0, Compare=0, Cause=0, EPC=0, BadVAddr=0, divider=0;
//   Status=32'h0040_0000 (BEV=1, EXL=0, IE=0, IM=0). Outputs follow registers (int_pending=0).
//  Map: 8 BadVAddr(RO), 9 Count, 11 Compare, 12 Status, 13 Cause, 14 EPC; others read 0, writes ignored.
//  Writable bits: Status IM[15:8], EXL[1], IE[0]; Cause IP[9:8] only; BadVAddr never by MTC0.
//  Read: combinational, no forwarding from same-cycle write (pipeline handles hazards).
//  Timer: divider counts 0..COUNT_DIV-1; Count+1 on wrap, modulo 2^32 (FFFF_FFFF->0).
//   Count==Compare (after update) and Compare!=0 sets Cause.TI[30] and IP[7]; stays set until MTC0 Compare.
//   MTC0 Count: loads value, resets divider, suppresses that cycle's increment.
//   MTC0 Compare: loads value, clears TI and IP[7] same edge.
//  Cause.IP[7:2]: IP[6:2] <= hw_int[4:0] each cycle; IP[7] <= hw_int[5] | TI.
//  Exception (exc_en): Cause.ExcCode<=exc_code; Status.EXL<=1;
//   if EXL was 0: EPC<=exc_delay_slot ? exc_pc-4 : exc_pc, Cause.BD<=exc_delay_slot; else EPC/BD unchanged.
//   BadVAddr<=exc_badvaddr only when exc_code is AdEL(4)/AdES(5).
//  ERET: Status.EXL<=0; other fields unchanged.
//  Priority same cycle: exc_en > eret > cp_write_en for the same field; write to non-conflicting
//   register still applies (e.g. exc_en + MTC0 Compare both take effect).
//  Latency: write visible on cp_read_data and status/cause/epc the cycle after the edge.
// STRUCTURE
//  Shared header cp0.v: CP0 register numbers, Status/Cause bit positions, ExcCode values,
//   reset value of Status; reuse `REG_ADDR_BUS and `DATA_BUS from bus.v.
//  Sub-module cp0_timer: divider, Count, Compare, TI flag; write-enables and data from top.
// TESTING
//  1 Reset: assert rst=0 two cycles -> status=0040_0000, cause=0, epc=0, int_pending=0, reads of 9/11=0.
//  2 MTC0 Status=FFFF_FFFF then MFC0 12 -> 0040_FF03; MTC0 reg 8 ignored; read reg 5 -> 0.
//  3 Count=FFFF_FFFE, COUNT_DIV=2 -> FFFF_FFFF after 2 clk, 0 after 4; Compare=5, Count reaches 5
//    -> cause[30]=1, int_pending=1 with IE=1,IM[7]=1; MTC0 Compare clears it next cycle.
//  4 exc_en, code=4, pc=8000_0100, delay_slot=1, badvaddr=1234_5671 -> epc=8000_00FC, BD=1,
//    ExcCode=4, EXL=1, BadVAddr=1234_5671; second exc_en (code 8) -> epc unchanged, ExcCode=8.
//  5 eret -> EXL=0; eret + exc_en same cycle -> EXL=1; exc_en + MTC0 Status(EXL=0) -> EXL=1.
//  6 hw_int=6'b000100, Status IM[4]=1, IE=1 -> int_pending=1 next cycle; drop hw_int -> 0;
//    rst mid-count (Count=37) -> Count=0, divider restarts.

Source files
------------

// File: rtl/cp0_reg_file_pkg.sv
// Shared CP0 definitions: register numbers, field positions, ExcCodes and reset values.
package cp0_reg_file_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 5;

    localparam logic [ADDR_W-1:0] REG_BADVADDR = 5'd8;
    localparam logic [ADDR_W-1:0] REG_COUNT    = 5'd9;
    localparam logic [ADDR_W-1:0] REG_COMPARE  = 5'd11;
    localparam logic [ADDR_W-1:0] REG_STATUS   = 5'd12;
    localparam logic [ADDR_W-1:0] REG_CAUSE    = 5'd13;
    localparam logic [ADDR_W-1:0] REG_EPC      = 5'd14;

    localparam int unsigned STATUS_IE    = 0;
    localparam int unsigned STATUS_EXL   = 1;
    localparam int unsigned STATUS_IM_LO = 8;
    localparam int unsigned STATUS_IM_HI = 15;
    localparam int unsigned CAUSE_SW_LO  = 8;
    localparam int unsigned CAUSE_SW_HI  = 9;

    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;

    localparam logic [DATA_W-1:0] STATUS_RESET = 32'h0040_0000;

    // Only address-error exceptions latch the faulting address.
    function automatic logic is_addr_exc(input logic [4:0] code);
        return (code == EXC_ADEL) || (code == EXC_ADES);
    endfunction

endpackage

// File: rtl/cp0_reg_file_timer.sv
// Count/Compare timer: prescaled Count, Compare register and sticky timer-interrupt flag.
module cp0_reg_file_timer
    import cp0_reg_file_pkg::*;
#(
    parameter int unsigned COUNT_DIV = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              count_we,
    input  logic              compare_we,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] count,
    output logic [DATA_W-1:0] compare,
    output logic              ti
);

    localparam int unsigned DIV_W = 2;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(COUNT_DIV - 1);

    logic [DIV_W-1:0]  div;
    logic [DIV_W-1:0]  div_n;
    logic [DATA_W-1:0] count_n;
    logic [DATA_W-1:0] compare_n;
    logic              ti_n;

    // A Count write reloads and restarts the prescaler, replacing that cycle's tick.
    always_comb begin
        div_n     = div;
        count_n   = count;
        compare_n = compare;
        ti_n      = ti;
        if (count_we) begin
            count_n = wdata;
            div_n   = '0;
        end else if (div == DIV_LAST) begin
            count_n = count + 32'd1;
            div_n   = '0;
        end else begin
            div_n = div + 2'd1;
        end
        if (compare_we) begin
            compare_n = wdata;
            ti_n      = 1'b0;
        end else if ((count_n == compare) && (compare != '0)) begin
            ti_n = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            div     <= '0;
            count   <= '0;
            compare <= '0;
            ti      <= 1'b0;
        end else begin
            div     <= div_n;
            count   <= count_n;
            compare <= compare_n;
            ti      <= ti_n;
        end
    end

endmodule

// File: rtl/cp0_reg_file.sv
// CP0 register file: MFC0/MTC0 access, exception/ERET bookkeeping, timer and interrupt pending.
module cp0_reg_file
    import cp0_reg_file_pkg::*;
#(
    parameter int unsigned COUNT_DIV = 2,
    parameter int unsigned INT_NUM   = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cp_read_en,
    input  logic [ADDR_W-1:0]  cp_read_addr,
    output logic [DATA_W-1:0]  cp_read_data,
    input  logic               cp_write_en,
    input  logic [ADDR_W-1:0]  cp_write_addr,
    input  logic [DATA_W-1:0]  cp_write_data,
    input  logic [INT_NUM-1:0] hw_int,
    input  logic               exc_en,
    input  logic [4:0]         exc_code,
    input  logic [DATA_W-1:0]  exc_pc,
    input  logic               exc_delay_slot,
    input  logic [DATA_W-1:0]  exc_badvaddr,
    input  logic               eret,
    output logic [DATA_W-1:0]  status,
    output logic [DATA_W-1:0]  cause,
    output logic [DATA_W-1:0]  epc,
    output logic               int_pending
);

    logic [7:0]         im, im_n;
    logic               exl, exl_n;
    logic               ie, ie_n;
    logic               bd, bd_n;
    logic [4:0]         code, code_n;
    logic [1:0]         ip_sw, ip_sw_n;
    logic [INT_NUM-1:0] ip_hw;
    logic [DATA_W-1:0]  epc_r, epc_n;
    logic [DATA_W-1:0]  badvaddr, badvaddr_n;
    logic [DATA_W-1:0]  count;
    logic [DATA_W-1:0]  compare;
    logic               ti;

    logic wr_count, wr_compare, wr_status, wr_cause, wr_epc;

    assign wr_count   = cp_write_en && (cp_write_addr == REG_COUNT);
    assign wr_compare = cp_write_en && (cp_write_addr == REG_COMPARE);
    assign wr_status  = cp_write_en && (cp_write_addr == REG_STATUS);
    assign wr_cause   = cp_write_en && (cp_write_addr == REG_CAUSE);
    assign wr_epc     = cp_write_en && (cp_write_addr == REG_EPC);

    cp0_reg_file_timer #(.COUNT_DIV(COUNT_DIV)) u_timer (
        .clk        (clk),
        .rst        (rst),
        .count_we   (wr_count),
        .compare_we (wr_compare),
        .wdata      (cp_write_data),
        .count      (count),
        .compare    (compare),
        .ti         (ti)
    );

    // Lowest priority applied first: MTC0, then ERET, then exception override.
    always_comb begin
        im_n       = im;
        exl_n      = exl;
        ie_n       = ie;
        bd_n       = bd;
        code_n     = code;
        ip_sw_n    = ip_sw;
        epc_n      = epc_r;
        badvaddr_n = badvaddr;
        if (wr_status) begin
            im_n  = cp_write_data[STATUS_IM_HI:STATUS_IM_LO];
            exl_n = cp_write_data[STATUS_EXL];
            ie_n  = cp_write_data[STATUS_IE];
        end
        if (wr_cause) begin
            ip_sw_n = cp_write_data[CAUSE_SW_HI:CAUSE_SW_LO];
        end
        if (wr_epc) begin
            epc_n = cp_write_data;
        end
        if (eret) begin
            exl_n = 1'b0;
        end
        if (exc_en) begin
            exl_n  = 1'b1;
            code_n = exc_code;
            if (!exl) begin
                bd_n  = exc_delay_slot;
                epc_n = exc_delay_slot ? (exc_pc - 32'd4) : exc_pc;
            end
            if (is_addr_exc(exc_code)) begin
                badvaddr_n = exc_badvaddr;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            im       <= '0;
            exl      <= 1'b0;
            ie       <= 1'b0;
            bd       <= 1'b0;
            code     <= '0;
            ip_sw    <= '0;
            ip_hw    <= '0;
            epc_r    <= '0;
            badvaddr <= '0;
        end else begin
            im       <= im_n;
            exl      <= exl_n;
            ie       <= ie_n;
            bd       <= bd_n;
            code     <= code_n;
            ip_sw    <= ip_sw_n;
            ip_hw    <= hw_int;
            epc_r    <= epc_n;
            badvaddr <= badvaddr_n;
        end
    end

    // IP[7] shares the top hardware line with the timer interrupt.
    assign status = STATUS_RESET | {16'd0, im, 6'd0, exl, ie};
    assign cause  = {bd, ti, 14'd0, ip_hw[5] | ti, ip_hw[4:0], ip_sw, 1'b0, code, 2'b00};
    assign epc    = epc_r;

    assign int_pending = ie && !exl && (|(cause[15:8] & im));

    always_comb begin
        cp_read_data = '0;
        if (cp_read_en) begin
            case (cp_read_addr)
                REG_BADVADDR: cp_read_data = badvaddr;
                REG_COUNT:    cp_read_data = count;
                REG_COMPARE:  cp_read_data = compare;
                REG_STATUS:   cp_read_data = status;
                REG_CAUSE:    cp_read_data = cause;
                REG_EPC:      cp_read_data = epc_r;
                default:      cp_read_data = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_cp0_reg_file.sv
// Scoreboard bench for cp0_reg_file: directed scenarios then random traffic against a behavioural model.
module tb_cp0_reg_file;

    localparam int unsigned COUNT_DIV = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        cp_read_en;
    logic [4:0]  cp_read_addr;
    logic [31:0] cp_read_data;
    logic        cp_write_en;
    logic [4:0]  cp_write_addr;
    logic [31:0] cp_write_data;
    logic [5:0]  hw_int;
    logic        exc_en;
    logic [4:0]  exc_code;
    logic [31:0] exc_pc;
    logic        exc_delay_slot;
    logic [31:0] exc_badvaddr;
    logic        eret;
    logic [31:0] status;
    logic [31:0] cause;
    logic [31:0] epc;
    logic        int_pending;

    always #5 clk = ~clk;

    cp0_reg_file #(.COUNT_DIV(COUNT_DIV), .INT_NUM(6)) dut (
        .clk            (clk),
        .rst            (rst),
        .cp_read_en     (cp_read_en),
        .cp_read_addr   (cp_read_addr),
        .cp_read_data   (cp_read_data),
        .cp_write_en    (cp_write_en),
        .cp_write_addr  (cp_write_addr),
        .cp_write_data  (cp_write_data),
        .hw_int         (hw_int),
        .exc_en         (exc_en),
        .exc_code       (exc_code),
        .exc_pc         (exc_pc),
        .exc_delay_slot (exc_delay_slot),
        .exc_badvaddr   (exc_badvaddr),
        .eret           (eret),
        .status         (status),
        .cause          (cause),
        .epc            (epc),
        .int_pending    (int_pending)
    );

    typedef struct {
        logic        rst;
        logic        re;
        logic [4:0]  ra;
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [5:0]  hw;
        logic        exc;
        logic [4:0]  code;
        logic [31:0] pc;
        logic        ds;
        logic [31:0] bad;
        logic        eret;
    } stim_t;

    typedef struct {
        logic [31:0] rd;
        logic [31:0] st;
        logic [31:0] ca;
        logic [31:0] ep;
        logic        ip;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   errors = 0;
    int   checks = 0;

    // Architectural state of the reference model.
    bit          m_valid = 1'b0;
    logic [31:0] m_count, m_compare, m_epc, m_bad;
    int          m_phase;
    logic        m_ti, m_exl, m_ie, m_bd;
    logic [7:0]  m_im;
    logic [4:0]  m_code;
    logic [1:0]  m_ipsw;
    logic [5:0]  m_hw;

    function automatic logic [31:0] m_status();
        return 32'h0040_0000 | (32'(m_im) << 8) | (32'(m_exl) << 1) | 32'(m_ie);
    endfunction

    function automatic logic [31:0] m_cause();
        logic [31:0] c;
        c        = '0;
        c[31]    = m_bd;
        c[30]    = m_ti;
        c[15]    = m_hw[5] | m_ti;
        c[14:10] = m_hw[4:0];
        c[9:8]   = m_ipsw;
        c[6:2]   = m_code;
        return c;
    endfunction

    function automatic logic [31:0] m_read(input logic en, input logic [4:0] a);
        if (!en) return 32'd0;
        case (a)
            5'd8:    return m_bad;
            5'd9:    return m_count;
            5'd11:   return m_compare;
            5'd12:   return m_status();
            5'd13:   return m_cause();
            5'd14:   return m_epc;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic m_int();
        logic [31:0] c;
        c = m_cause();
        return m_ie && !m_exl && ((c[15:8] & m_im) != 8'd0);
    endfunction

    task automatic model_step(input stim_t s);
        logic old_exl;
        if (!s.rst) begin
            m_count = 0; m_compare = 0; m_epc = 0; m_bad = 0; m_phase = 0;
            m_ti = 0; m_exl = 0; m_ie = 0; m_bd = 0; m_im = 0; m_code = 0;
            m_ipsw = 0; m_hw = 0; m_valid = 1'b1;
            return;
        end
        if (s.we && s.wa == 5'd9) begin
            m_count = s.wd;
            m_phase = 0;
        end else begin
            m_phase = m_phase + 1;
            if (m_phase == COUNT_DIV) begin
                m_phase = 0;
                m_count = m_count + 1;
            end
        end
        if (s.we && s.wa == 5'd11) begin
            m_compare = s.wd;
            m_ti = 1'b0;
        end else if (m_count == m_compare && m_compare != 0) begin
            m_ti = 1'b1;
        end
        m_hw = s.hw;
        old_exl = m_exl;
        if (s.we && s.wa == 5'd12) begin
            m_im = s.wd[15:8];
            m_exl = s.wd[1];
            m_ie = s.wd[0];
        end
        if (s.we && s.wa == 5'd13) m_ipsw = s.wd[9:8];
        if (s.we && s.wa == 5'd14) m_epc = s.wd;
        if (s.eret) m_exl = 1'b0;
        if (s.exc) begin
            m_exl = 1'b1;
            m_code = s.code;
            if (!old_exl) begin
                m_bd = s.ds;
                m_epc = s.ds ? s.pc - 32'd4 : s.pc;
            end
            if (s.code == 5'd4 || s.code == 5'd5) m_bad = s.bad;
        end
    endtask

    // Drive one cycle; expectation is what the DUT must show before the next edge.
    task automatic apply(input stim_t s);
        exp_t e;
        @(posedge clk);
        #1;
        rst = s.rst; cp_read_en = s.re; cp_read_addr = s.ra;
        cp_write_en = s.we; cp_write_addr = s.wa; cp_write_data = s.wd;
        hw_int = s.hw; exc_en = s.exc; exc_code = s.code; exc_pc = s.pc;
        exc_delay_slot = s.ds; exc_badvaddr = s.bad; eret = s.eret;
        if (m_valid) begin
            e.rd = m_read(s.re, s.ra);
            e.st = m_status();
            e.ca = m_cause();
            e.ep = m_epc;
            e.ip = m_int();
            sb.push_back(e);
        end
        model_step(s);
    endtask

    function automatic stim_t idle();
        stim_t s;
        s = '{rst: 1'b1, re: 1'b0, ra: 5'd0, we: 1'b0, wa: 5'd0, wd: 32'd0, hw: 6'd0,
              exc: 1'b0, code: 5'd0, pc: 32'd0, ds: 1'b0, bad: 32'd0, eret: 1'b0};
        return s;
    endfunction

    function automatic stim_t mk_rd(input logic [4:0] a);
        stim_t s;
        s = idle();
        s.re = 1'b1;
        s.ra = a;
        return s;
    endfunction

    function automatic stim_t mk_wr(input logic [4:0] a, input logic [31:0] d);
        stim_t s;
        s = idle();
        s.we = 1'b1;
        s.wa = a;
        s.wd = d;
        return s;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                mon_e = sb.pop_front();
                check("cp_read_data", cp_read_data, mon_e.rd);
                check("status", status, mon_e.st);
                check("cause", cause, mon_e.ca);
                check("epc", epc, mon_e.ep);
                check("int_pending", {31'd0, int_pending}, {31'd0, mon_e.ip});
            end
        end
    end

    function automatic logic [4:0] pick_addr();
        logic [4:0] tbl [7];
        tbl = '{5'd8, 5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd0};
        tbl[6] = 5'($urandom_range(0, 31));
        return tbl[$urandom_range(0, 6)];
    endfunction

    initial begin
        stim_t s;
        rst = 1'b0; cp_read_en = 0; cp_read_addr = 0; cp_write_en = 0; cp_write_addr = 0;
        cp_write_data = 0; hw_int = 0; exc_en = 0; exc_code = 0; exc_pc = 0;
        exc_delay_slot = 0; exc_badvaddr = 0; eret = 0;

        s = idle(); s.rst = 1'b0;
        apply(s); apply(s);
        apply(mk_rd(5'd9)); apply(mk_rd(5'd11));

        apply(mk_wr(5'd12, 32'hFFFF_FFFF)); apply(mk_rd(5'd12));
        apply(mk_wr(5'd8, 32'hDEAD_BEEF)); apply(mk_rd(5'd8)); apply(mk_rd(5'd5));

        apply(mk_wr(5'd9, 32'hFFFF_FFFE));
        repeat (5) apply(mk_rd(5'd9));
        apply(mk_wr(5'd12, 32'h0000_8001));
        apply(mk_wr(5'd11, 32'd5));
        repeat (16) apply(mk_rd(5'd13));
        apply(mk_wr(5'd11, 32'd0));
        apply(mk_rd(5'd13));

        s = idle(); s.exc = 1; s.code = 5'd4; s.pc = 32'h8000_0100; s.ds = 1;
        s.bad = 32'h1234_5671;
        apply(s); apply(mk_rd(5'd8));
        s.code = 5'd8; s.pc = 32'h8000_0200; s.ds = 0; s.bad = 32'h5555_0000;
        apply(s); apply(mk_rd(5'd14));

        s = idle(); s.eret = 1; apply(s); apply(mk_rd(5'd12));
        s.exc = 1; s.code = 5'd10; apply(s); apply(mk_rd(5'd12));
        s = mk_wr(5'd12, 32'h0000_0000); s.exc = 1; s.code = 5'd12; apply(s);
        apply(mk_rd(5'd12));

        s = idle(); s.eret = 1; apply(s);
        apply(mk_wr(5'd12, 32'h0000_1001));
        s = mk_rd(5'd13); s.hw = 6'b000100;
        repeat (3) apply(s);
        s.hw = 6'd0;
        repeat (2) apply(s);
        apply(mk_wr(5'd9, 32'd37));
        repeat (3) apply(mk_rd(5'd9));
        s = mk_rd(5'd9); s.rst = 1'b0; apply(s);
        repeat (4) apply(mk_rd(5'd9));

        for (int i = 0; i < 3000; i++) begin
            s = idle();
            s.rst  = ($urandom_range(0, 149) != 0);
            s.re   = ($urandom_range(0, 3) != 0);
            s.ra   = pick_addr();
            s.we   = ($urandom_range(0, 2) == 0);
            s.wa   = pick_addr();
            s.wd   = $urandom;
            if (s.wa == 5'd9 && $urandom_range(0, 1) == 1) s.wd = m_compare - 32'($urandom_range(0, 6));
            if (s.wa == 5'd11 && $urandom_range(0, 1) == 1) s.wd = 32'($urandom_range(0, 40));
            s.hw   = ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'd0;
            s.exc  = ($urandom_range(0, 9) == 0);
            s.code = ($urandom_range(0, 1) == 1) ? 5'($urandom_range(4, 5)) : 5'($urandom);
            s.pc   = $urandom;
            s.ds   = 1'($urandom);
            s.bad  = $urandom;
            s.eret = ($urandom_range(0, 9) == 0);
            if (s.exc && s.we && s.wa == 5'd14) s.we = 1'b0;
            apply(s);
        end

        for (int i = 0; i < 10 && sb.size() > 0; i++) begin
            @(negedge clk);
            #1;
        end
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d expectations left, required 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
